wired_bpu_gshare: RTL and testbench



---
 rtl/wired_bpu_gshare.sv | 214 +++++++++++++++++++++
 tb/tb_wired_bpu_gshare.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_bpu_gshare.sv
// wired_bpu_gshare: gshare direction predictor for the Wired front end.
// FETCH_W banks of 2-bit saturating counters indexed by PC ^ GHR, a registered
// one-cycle prediction, a two-stage update pipe with forwarding, a speculative
// GHR with mispredict recovery, and a post-reset sweep that initialises the table.
// Optional build macro: WIRED_BPU_PERF_EN adds prediction/mispredict counters.
module wired_bpu_gshare #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned FETCH_W = 4,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned GHR_W   = 12,
  parameter int unsigned OFF_W   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           preq_valid_i,
  output logic                                           preq_ready_o,
  input  logic [ADDR_W-1:0]                              preq_pc_i,
  output logic                                           pred_valid_o,
  output logic [FETCH_W-1:0]                             pred_taken_o,
  output logic [GHR_W-1:0]                               pred_ghr_o,
  input  logic                                           upd_valid_i,
  output logic                                           upd_ready_o,
  input  logic [ADDR_W-1:0]                              upd_pc_i,
  input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] upd_slot_i,
  input  logic [GHR_W-1:0]                               upd_ghr_i,
  input  logic                                           upd_taken_i,
  input  logic                                           upd_mispred_i
`ifdef WIRED_BPU_PERF_EN
  ,
  output logic [31:0]                                    perf_pred_o,
  output logic [31:0]                                    perf_mispred_o
`endif
);

  localparam int unsigned SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  // A history shorter than the index would leave index bits unhashed
  if (GHR_W < IDX_W) begin : g_bad_ghr
    $error("wired_bpu_gshare: GHR_W must be >= IDX_W");
  end

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_nxt_c;
  logic [IDX_W-1:0]     sweep_ptr;
  logic                 sweep_last_c;
  logic                 sweep_we_c;
  logic                 run_nxt_c;
  logic                 run_q;

  logic [GHR_W-1:0]     ghr;
  logic [IDX_W-1:0]     pidx_c;
  logic [IDX_W-1:0]     uidx_c;
  logic                 preq_acc_c;
  logic                 upd_acc_c;
  logic [FETCH_W-1:0]   pred_bit_c;
  logic [FETCH_W-1:0][1:0] upd_cnt_c;

  logic                 u2_valid;
  logic [SLOT_W-1:0]    u2_slot;
  logic [IDX_W-1:0]     u2_idx;
  logic [1:0]           u2_wdata;

  logic                 unused_bits;

  // Next value of a 2-bit saturating counter
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && (cnt != 2'b11)) begin
      res = cnt + 2'b01;
    end else if (!taken && (cnt != 2'b00)) begin
      res = cnt - 2'b01;
    end
    return res;
  endfunction

  assign sweep_last_c = (sweep_ptr == IDX_W'(DEPTH - 1));
  assign preq_acc_c   = preq_valid_i & run_q;
  assign upd_acc_c    = upd_valid_i & run_q;
  assign preq_ready_o = run_q;
  assign upd_ready_o  = run_q;
  assign unused_bits  = ^{preq_pc_i, upd_pc_i, upd_ghr_i};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // FSM next state: leave INIT once the last index has been swept
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      ST_INIT: if (sweep_last_c) state_nxt_c = ST_RUN;
      ST_RUN:  state_nxt_c = ST_RUN;
      default: state_nxt_c = ST_INIT;
    endcase
  end

  // FSM outputs: sweep write enable in INIT, readiness once RUN is entered
  always_comb begin
    sweep_we_c = 1'b0;
    run_nxt_c  = 1'b0;
    if (state_q == ST_INIT) sweep_we_c = 1'b1;
    if (state_nxt_c == ST_RUN) run_nxt_c = 1'b1;
  end

  // Sweep pointer and registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_ptr <= '0;
      run_q     <= 1'b0;
    end else begin
      run_q <= run_nxt_c;
      if (sweep_we_c) sweep_ptr <= sweep_ptr + IDX_W'(1);
    end
  end

  // Gshare indices for the prediction and update ports
  always_comb begin
    pidx_c = preq_pc_i[OFF_W+IDX_W-1:OFF_W] ^ ghr[IDX_W-1:0];
    uidx_c = upd_pc_i[OFF_W+IDX_W-1:OFF_W] ^ upd_ghr_i[IDX_W-1:0];
  end

  for (genvar b = 0; b < FETCH_W; b++) begin : g_bank
    logic [1:0] mem [DEPTH];
    logic       wr_hit_c;

    assign wr_hit_c = u2_valid && (u2_slot == SLOT_W'(b));

    // Table write: sweep initialisation or U2 counter write
    always_ff @(posedge clk) begin
      if (sweep_we_c) begin
        mem[sweep_ptr] <= 2'b01;
      end else if (wr_hit_c) begin
        mem[u2_idx] <= u2_wdata;
      end
    end

    // Table reads, forwarding the in-flight U2 write on an index hit
    always_comb begin
      pred_bit_c[b] = mem[pidx_c][1];
      upd_cnt_c[b]  = mem[uidx_c];
      if (wr_hit_c && (u2_idx == pidx_c)) pred_bit_c[b] = u2_wdata[1];
      if (wr_hit_c && (u2_idx == uidx_c)) upd_cnt_c[b]  = u2_wdata;
    end
  end

  // Registered prediction outputs; direction and snapshot hold between accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= '0;
      pred_ghr_o   <= '0;
    end else begin
      pred_valid_o <= preq_acc_c;
      if (preq_acc_c) begin
        pred_taken_o <= pred_bit_c;
        pred_ghr_o   <= ghr;
      end
    end
  end

  // Global history: mispredict recovery overrides the speculative shift
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_acc_c && upd_mispred_i) begin
      ghr <= {upd_ghr_i[GHR_W-2:0], upd_taken_i};
    end else if (preq_acc_c) begin
      ghr <= {ghr[GHR_W-2:0], |pred_bit_c};
    end
  end

  // U1 stage: read (forwarded) counter and precompute the U2 write value
  always_ff @(posedge clk) begin
    if (rst) begin
      u2_valid <= 1'b0;
      u2_slot  <= '0;
      u2_idx   <= '0;
      u2_wdata <= 2'b00;
    end else begin
      u2_valid <= upd_acc_c;
      if (upd_acc_c) begin
        u2_slot  <= upd_slot_i;
        u2_idx   <= uidx_c;
        u2_wdata <= sat_next(upd_cnt_c[upd_slot_i], upd_taken_i);
      end
    end
  end

`ifdef WIRED_BPU_PERF_EN
  // Wrapping event counters, frozen while the table is being swept
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pred_o    <= '0;
      perf_mispred_o <= '0;
    end else if (state_q == ST_RUN) begin
      if (preq_acc_c) perf_pred_o <= perf_pred_o + 32'd1;
      if (upd_acc_c && upd_mispred_i) perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wired_bpu_gshare.sv
// tb_wired_bpu_gshare: directed and random checks of wired_bpu_gshare against a
// transaction-level model (counter table as int array, GHR as integer arithmetic).
module tb_wired_bpu_gshare;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned FETCH_W = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned GHR_W   = 12;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned DEPTH   = 1 << IDX_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               preq_valid = 1'b0;
  logic               preq_ready;
  logic [ADDR_W-1:0]  preq_pc = '0;
  logic               pred_valid;
  logic [FETCH_W-1:0] pred_taken;
  logic [GHR_W-1:0]   pred_ghr;
  logic               upd_valid = 1'b0;
  logic               upd_ready;
  logic [ADDR_W-1:0]  upd_pc = '0;
  logic [1:0]         upd_slot = '0;
  logic [GHR_W-1:0]   upd_ghr = '0;
  logic               upd_taken = 1'b0;
  logic               upd_mispred = 1'b0;
`ifdef WIRED_BPU_PERF_EN
  logic [31:0]        perf_pred;
  logic [31:0]        perf_mispred;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int                 m_pht [FETCH_W][DEPTH];
  int                 m_ghr;
  bit                 m_run;
  bit                 pend_v;
  int                 pend_s;
  int                 pend_i;
  bit                 pend_t;
  bit                 e_valid;
  logic [FETCH_W-1:0] e_taken;
  int                 e_ghr;
  int                 m_perf_pred;
  int                 m_perf_mis;

  wired_bpu_gshare #(
    .ADDR_W (ADDR_W),
    .FETCH_W(FETCH_W),
    .IDX_W  (IDX_W),
    .GHR_W  (GHR_W),
    .OFF_W  (OFF_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .preq_valid_i (preq_valid),
    .preq_ready_o (preq_ready),
    .preq_pc_i    (preq_pc),
    .pred_valid_o (pred_valid),
    .pred_taken_o (pred_taken),
    .pred_ghr_o   (pred_ghr),
    .upd_valid_i  (upd_valid),
    .upd_ready_o  (upd_ready),
    .upd_pc_i     (upd_pc),
    .upd_slot_i   (upd_slot),
    .upd_ghr_i    (upd_ghr),
    .upd_taken_i  (upd_taken),
    .upd_mispred_i(upd_mispred)
`ifdef WIRED_BPU_PERF_EN
    ,
    .perf_pred_o   (perf_pred),
    .perf_mispred_o(perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model table index: drop offset bits, take IDX_W bits, hash with history
  function automatic int m_idx(input logic [31:0] pc, input int hist);
    return int'((pc >> OFF_W) % DEPTH) ^ (hist % DEPTH);
  endfunction

  // Assert reset for hold cycles and put the model into its post-reset state
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    preq_valid = 1'b0;
    upd_valid = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < FETCH_W; s++)
      for (int i = 0; i < DEPTH; i++) m_pht[s][i] = 1;
    m_ghr = 0; m_run = 0; pend_v = 0;
    e_valid = 0; e_taken = '0; e_ghr = 0;
    m_perf_pred = 0; m_perf_mis = 0;
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_ghr", 32'(pred_ghr), 32'd0);
  endtask

  // Count cycles with ready low after reset release (bounded)
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (preq_ready !== 1'b1 && n < 100) begin
      if (upd_ready !== 1'b0) chk({tag, "_upd_ready_init"}, 32'(upd_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), DEPTH);
    chk({tag, "_upd_ready"}, 32'(upd_ready), 32'd1);
    m_run = 1;
  endtask

  // One clock: drive inputs, advance the model, check registered outputs
  task automatic cyc(input bit pv, input logic [31:0] ppc, input bit uv,
                     input logic [31:0] upc, input int us, input int ug,
                     input bit ut, input bit um);
    int pi;
    int v;
    @(negedge clk);
    preq_valid = pv; preq_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_slot = 2'(us);
    upd_ghr = 12'(ug); upd_taken = ut; upd_mispred = um;
    // Last cycle's update commits before this cycle's reads
    if (pend_v) begin
      v = m_pht[pend_s][pend_i];
      if (pend_t) v = (v < 3) ? v + 1 : 3;
      else        v = (v > 0) ? v - 1 : 0;
      m_pht[pend_s][pend_i] = v;
      pend_v = 0;
    end
    e_valid = 0;
    if (pv && m_run) begin
      pi = m_idx(ppc, m_ghr);
      for (int s = 0; s < FETCH_W; s++) e_taken[s] = (m_pht[s][pi] >= 2);
      e_ghr = m_ghr;
      e_valid = 1;
      m_ghr = (m_ghr * 2 + ((e_taken != 0) ? 1 : 0)) % (1 << GHR_W);
      m_perf_pred++;
    end
    if (uv && m_run) begin
      pend_v = 1; pend_s = us; pend_i = m_idx(upc, ug); pend_t = ut;
      if (um) begin
        m_ghr = (ug * 2 + (ut ? 1 : 0)) % (1 << GHR_W);
        m_perf_mis++;
      end
    end
    @(posedge clk);
    #1;
    chk("pred_valid", 32'(pred_valid), 32'(e_valid));
    chk("pred_taken", 32'(pred_taken), 32'(e_taken));
    chk("pred_ghr", 32'(pred_ghr), 32'(e_ghr));
    chk("preq_ready", 32'(preq_ready), 32'(m_run));
    chk("upd_ready", 32'(upd_ready), 32'(m_run));
  endtask

  task automatic pred(input logic [31:0] pc);
    cyc(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input int s, input int g, input bit t, input bit m);
    cyc(0, 0, 1, pc, s, g, t, m);
  endtask

  initial begin
    // Reset and initial sweep
    do_reset(2);
    wait_ready("init_ready_cycles");

    // First prediction after sweep: all weakly not-taken
    pred(32'h0);
    chk("first_taken", 32'(pred_taken), 32'd0);
    chk("first_ghr", 32'(pred_ghr), 32'd0);

    // Back-to-back taken updates, slot 2: 01 -> 10 -> 11
    upd(32'h40, 2, 0, 1, 0);
    upd(32'h40, 2, 0, 1, 0);
    pred(32'h40);
    chk("b2b_taken_slot2", 32'(pred_taken[2]), 32'd1);

    // Not-taken saturation at 00 (last one restores GHR to 0)
    upd(32'h80, 1, 0, 0, 0);
    upd(32'h80, 1, 0, 0, 0);
    upd(32'h80, 1, 0, 0, 1);
    pred(32'h80);
    chk("sat_low_slot1", 32'(pred_taken[1]), 32'd0);

    // Climb to 11 then one more taken; GHR recovers to 1
    upd(32'h80, 1, 0, 1, 0);
    upd(32'h80, 1, 0, 1, 0);
    upd(32'h80, 1, 0, 1, 0);
    upd(32'h80, 1, 0, 1, 1);
    pred(32'h90);
    chk("sat_high_a", 32'(pred_taken[1]), 32'd1);
    upd(32'h80, 1, 0, 1, 0);
    upd(32'h80, 1, 0, 1, 0);
    upd(32'h80, 1, 0, 1, 1);
    pred(32'h90);
    chk("sat_high_b", 32'(pred_taken[1]), 32'd1);

    // GHR to 0x005, taken prediction shifts to 0x00B, then recovery to 0x00A
    upd(32'hF0, 0, 12'h002, 1, 1);
    pred(32'h10);
    chk("ghr5_snapshot", 32'(pred_ghr), 32'h005);
    chk("ghr5_taken", 32'(pred_taken[2]), 32'd1);
    cyc(1, 32'h20, 1, 32'h00, 0, 12'h005, 0, 1);
    chk("recov_pred_valid", 32'(pred_valid), 32'd1);
    chk("recov_pred_ghr", 32'(pred_ghr), 32'h00B);
    pred(32'h00);
    chk("recov_ghr_a", 32'(pred_ghr), 32'h00A);

    // Prediction read colliding with the U2 write sees the new counter
    upd(32'hC0, 3, 0, 1, 1);
    pred(32'hD0);
    chk("hazard_slot3", 32'(pred_taken[3]), 32'd1);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom & 32'hFF,
          $urandom_range(0, 1) == 1, $urandom & 32'hFF,
          int'($urandom_range(0, 3)), int'($urandom & 32'hFFF),
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    // Reset in the middle of the sweep restarts it from index 0
    do_reset(1);
    repeat (7) @(negedge clk);
    chk("mid_sweep_ready", 32'(preq_ready), 32'd0);
    do_reset(1);
    wait_ready("restart_ready_cycles");

    for (int k = 0; k < 60; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom & 32'hFF,
          $urandom_range(0, 1) == 1, $urandom & 32'hFF,
          int'($urandom_range(0, 3)), int'($urandom & 32'hFFF),
          $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
    end

`ifdef WIRED_BPU_PERF_EN
    chk("perf_pred", perf_pred, 32'(m_perf_pred));
    chk("perf_mispred", perf_mispred, 32'(m_perf_mis));
`endif

    @(negedge clk);
    preq_valid = 1'b0;
    upd_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
